// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM state encoding and defaults for the UART TX arbiter.
package uart_tx_arbiter_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT_RISE, ST_WAIT_FALL} state_e;
   localparam int DEFAULT_DATA_W = 8;
endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority encoder; first request at or after i_ptr wins.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);
   always_comb begin
      logic [IW-1:0] j;
      j = '0;
      o_gnt = '0;
      o_idx = '0;
      o_valid = 1'b0;
      // scan from farthest to nearest so the nearest match at or after i_ptr is written last
      for (int k = N - 1; k >= 0; k--) begin
         j = IW'((int'(i_ptr) + k) % N);
         if (i_req[j]) begin
            o_valid = 1'b1;
            o_idx = j;
         end
      end
      o_gnt[o_idx] = o_valid;
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx between N_REQ byte sources,
// with packet lock held until the byte flagged last.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int DATA_W        = DEFAULT_DATA_W,
   parameter int BUSY_WAIT_MAX = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          i_req,
   input  logic [N_REQ-1:0]          i_last,
   input  logic [N_REQ*DATA_W-1:0]   i_data,
   output logic [N_REQ-1:0]          o_ack,
   output logic [N_REQ-1:0]          o_grant,
   output logic                      o_tx_start,
   output logic [DATA_W-1:0]         o_tx_data,
   input  logic                      i_tx_busy,
   output logic                      o_err_timeout
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(BUSY_WAIT_MAX + 1);

   state_e              r_state, w_state;
   logic                r_lock, w_lock;
   logic [IW-1:0]       r_owner, w_owner;
   logic [IW-1:0]       r_ptr, w_ptr;
   logic [CW-1:0]       r_cnt, w_cnt;
   logic [DATA_W-1:0]   r_tx_data, w_tx_data;
   logic [N_REQ-1:0]    r_ack, w_ack;
   logic [N_REQ-1:0]    r_grant, w_grant;
   logic                r_start, w_start;
   logic                r_err, w_err;

   logic [N_REQ-1:0]    w_arb_gnt;
   logic [IW-1:0]       w_arb_idx;
   logic                w_arb_valid;
   logic [IW-1:0]       w_win;
   logic [N_REQ-1:0]    w_onehot;
   logic                w_go;

   rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
      .i_req   (i_req),
      .i_ptr   (r_ptr),
      .o_gnt   (w_arb_gnt),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
   );

   // a locked owner bypasses the arbiter entirely; nobody else can win meanwhile
   assign w_win    = r_lock ? r_owner : w_arb_idx;
   assign w_onehot = r_lock ? N_REQ'(1) << r_owner : w_arb_gnt;
   assign w_go     = !i_tx_busy && (r_lock ? i_req[r_owner] : w_arb_valid);

   always_comb begin
      w_state   = r_state;
      w_lock    = r_lock;
      w_owner   = r_owner;
      w_ptr     = r_ptr;
      w_cnt     = r_cnt;
      w_tx_data = r_tx_data;
      w_ack     = '0;
      w_grant   = r_grant;
      w_start   = 1'b0;
      w_err     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_lock && !i_req[r_owner]) begin
               w_lock  = 1'b0;
               w_grant = '0;
            end else if (w_go) begin
               w_tx_data = i_data[int'(w_win)*DATA_W +: DATA_W];
               w_start   = 1'b1;
               w_ack     = w_onehot;
               w_grant   = w_onehot;
               w_lock    = !i_last[w_win];
               w_owner   = w_win;
               w_ptr     = IW'((int'(w_win) + 1) % N_REQ);
               w_state   = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            w_cnt   = '0;
            w_state = ST_WAIT_RISE;
         end
         ST_WAIT_RISE: begin
            if (i_tx_busy) begin
               w_state = ST_WAIT_FALL;
            end else if (r_cnt == CW'(BUSY_WAIT_MAX - 1)) begin
               w_err   = 1'b1;
               w_lock  = 1'b0;
               w_grant = '0;
               w_state = ST_IDLE;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         ST_WAIT_FALL: begin
            if (!i_tx_busy) begin
               w_state = ST_IDLE;
               w_grant = r_lock ? r_grant : '0;
            end
         end
         default: w_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_lock    <= 1'b0;
         r_owner   <= '0;
         r_ptr     <= '0;
         r_cnt     <= '0;
         r_tx_data <= '0;
         r_ack     <= '0;
         r_grant   <= '0;
         r_start   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_lock    <= w_lock;
         r_owner   <= w_owner;
         r_ptr     <= w_ptr;
         r_cnt     <= w_cnt;
         r_tx_data <= w_tx_data;
         r_ack     <= w_ack;
         r_grant   <= w_grant;
         r_start   <= w_start;
         r_err     <= w_err;
      end
   end

   assign o_ack         = r_ack;
   assign o_grant       = r_grant;
   assign o_tx_start    = r_start;
   assign o_tx_data     = r_tx_data;
   assign o_err_timeout = r_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: byte sources plus a behavioural uart_tx model around the arbiter;
// expected byte/grant order comes from a packet-level round-robin model.
module tb_uart_tx_arbiter;
   localparam int N = 4;
   localparam int W = 8;
   localparam int MAXW = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req, last, ack, grant;
   logic [N*W-1:0] data;
   logic           tx_start, tx_busy, err;
   logic [W-1:0]   tx_data;

   int checks = 0;
   int errors = 0;

   logic [7:0] sd [N][16];
   bit         sl [N][16];
   int         slen [N];
   int         spos [N];
   int         sstop [N];
   bit         sen [N];

   bit         tx_en = 1'b1;
   bit         hold_long = 1'b0;
   bit         cap_valid = 1'b0;
   logic [7:0] cap;
   int         rise_cnt, busy_cnt;
   logic [7:0] rx_q [$];
   logic [3:0] g_q [$];
   logic [7:0] exp_q [$];
   logic [3:0] eg_q [$];

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .BUSY_WAIT_MAX(MAXW)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_req         (req),
      .i_last        (last),
      .i_data        (data),
      .o_ack         (ack),
      .o_grant       (grant),
      .o_tx_start    (tx_start),
      .o_tx_data     (tx_data),
      .i_tx_busy     (tx_busy),
      .o_err_timeout (err)
   );

   // byte sources: present the next byte, advance after each ack
   initial begin
      req = '0;
      last = '0;
      data = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (ack[i]) spos[i]++;
            req[i] = sen[i] && spos[i] < slen[i] && spos[i] < sstop[i];
            data[i*W +: W] = sd[i][spos[i] % 16];
            last[i] = sl[i][spos[i] % 16];
         end
      end
   end

   // uart_tx model: no reset, busy rises 1..4 cycles after start and lasts a few cycles
   initial begin
      tx_busy = 1'b0;
      rise_cnt = 0;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) cap_valid = 1'b0;
         if (rise_cnt > 0) begin
            rise_cnt--;
            if (rise_cnt == 0) begin
               tx_busy = 1'b1;
               busy_cnt = hold_long ? 20 : int'($urandom_range(1, 6));
            end
         end else if (tx_busy) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
               tx_busy = 1'b0;
               if (cap_valid) begin
                  checks++;
                  if (tx_data !== cap) begin
                     errors++;
                     $display("FAIL tx_data_hold got %h want %h", tx_data, cap);
                  end
               end
            end
         end
         if (tx_start && tx_en) begin
            rx_q.push_back(tx_data);
            g_q.push_back(grant);
            cap = tx_data;
            cap_valid = 1'b1;
            rise_cnt = int'($urandom_range(1, 4));
            checks++;
            if (ack !== grant || !$onehot(grant)) begin
               errors++;
               $display("FAIL ack_grant_at_start ack %b grant %b want equal one-hot", ack, grant);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic clear_sources();
      for (int i = 0; i < N; i++) begin
         slen[i] = 0;
         spos[i] = 0;
         sstop[i] = 99;
         sen[i] = 1'b0;
      end
      rx_q.delete();
      g_q.delete();
      exp_q.delete();
      eg_q.delete();
   endtask

   task automatic add_byte(input int i, input logic [7:0] b, input bit l);
      sd[i][slen[i]] = b;
      sl[i][slen[i]] = l;
      slen[i]++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_rx(input int n);
      int c = 0;
      while (rx_q.size() < n && c < 3000) begin
         @(negedge clk);
         c++;
      end
      repeat (40) @(negedge clk);
   endtask

   task automatic wait_ack(input int i);
      int c = 0;
      while (!ack[i] && c < 200) begin
         @(negedge clk);
         c++;
      end
   endtask

   task automatic test_reset();
      int c;
      int bad;
      clear_sources();
      rst = 1'b1;
      do_reset();
      checks++;
      if ({ack, grant, tx_start, err, tx_data} !== '0) begin
         errors++;
         $display("FAIL reset_state got %h want 0", {ack, grant, tx_start, err, tx_data});
      end
      hold_long = 1'b1;
      add_byte(0, 8'hA5, 1'b1);
      sen[0] = 1'b1;
      c = 0;
      while (!tx_busy && c < 30) begin
         @(negedge clk);
         c++;
      end
      hold_long = 1'b0;
      checks++;
      if (!tx_busy) begin
         errors++;
         $display("FAIL reset_busy_rise got %b want 1", tx_busy);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({ack, grant, tx_start, err, tx_data} !== '0) begin
         errors++;
         $display("FAIL reset_mid_byte got %h want 0", {ack, grant, tx_start, err, tx_data});
      end
      add_byte(1, 8'h3C, 1'b1);
      sen[1] = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bad = 0;
      c = 0;
      while (tx_busy && c < 40) begin
         @(negedge clk);
         if (tx_busy && tx_start) bad++;
         c++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_start_while_busy got %0d want 0", bad);
      end
      wait_rx(2);
      checks++;
      if (rx_q.size() != 2 || rx_q[1] !== 8'h3C) begin
         errors++;
         $display("FAIL reset_resume got size %0d want 2 with byte 3c", rx_q.size());
      end
   endtask

   task automatic test_single();
      clear_sources();
      do_reset();
      add_byte(0, 8'h41, 1'b1);
      sen[0] = 1'b1;
      wait_ack(0);
      checks++;
      if (ack !== 4'b0001 || !tx_start || tx_data !== 8'h41 || grant !== 4'b0001) begin
         errors++;
         $display("FAIL single_launch ack %b start %b data %h grant %b want 0001 1 41 0001",
                  ack, tx_start, tx_data, grant);
      end
      @(negedge clk);
      checks++;
      if (ack !== 4'b0000 || tx_start !== 1'b0) begin
         errors++;
         $display("FAIL single_pulse ack %b start %b want 0000 0", ack, tx_start);
      end
      wait_rx(1);
      checks++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h41) begin
         errors++;
         $display("FAIL single_rx got size %0d want 1 byte 41", rx_q.size());
      end
      checks++;
      if (grant !== 4'b0000) begin
         errors++;
         $display("FAIL single_idle_grant got %b want 0000", grant);
      end
   endtask

   task automatic test_round_robin();
      clear_sources();
      do_reset();
      add_byte(0, 8'h10, 1'b1);
      add_byte(0, 8'h10, 1'b1);
      add_byte(1, 8'h11, 1'b1);
      add_byte(2, 8'h12, 1'b1);
      add_byte(3, 8'h13, 1'b1);
      exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      eg_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < N; i++) sen[i] = 1'b1;
      wait_rx(5);
      checks++;
      if (rx_q.size() != 5) begin
         errors++;
         $display("FAIL rr_count got %0d want 5", rx_q.size());
      end
      for (int k = 0; k < 5 && k < rx_q.size(); k++) begin
         checks++;
         if (rx_q[k] !== exp_q[k] || g_q[k] !== eg_q[k]) begin
            errors++;
            $display("FAIL rr_byte%0d got %h/%b want %h/%b", k, rx_q[k], g_q[k], exp_q[k], eg_q[k]);
         end
      end
   endtask

   task automatic test_packet_lock();
      clear_sources();
      do_reset();
      add_byte(2, 8'h48, 1'b0);
      add_byte(2, 8'h45, 1'b0);
      add_byte(2, 8'h4C, 1'b0);
      add_byte(2, 8'h4C, 1'b0);
      add_byte(2, 8'h4F, 1'b1);
      add_byte(1, 8'h55, 1'b1);
      exp_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h55};
      sen[2] = 1'b1;
      wait_ack(2);
      sen[1] = 1'b1;
      wait_rx(6);
      checks++;
      if (rx_q.size() != 6) begin
         errors++;
         $display("FAIL lock_count got %0d want 6", rx_q.size());
      end
      for (int k = 0; k < 6 && k < rx_q.size(); k++) begin
         checks++;
         if (rx_q[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL lock_byte%0d got %h want %h", k, rx_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_abandon();
      clear_sources();
      do_reset();
      add_byte(3, 8'h31, 1'b0);
      add_byte(3, 8'h32, 1'b0);
      add_byte(3, 8'h33, 1'b0);
      add_byte(3, 8'h34, 1'b1);
      sstop[3] = 2;
      add_byte(0, 8'h07, 1'b1);
      exp_q = '{8'h31, 8'h32, 8'h07};
      eg_q = '{4'b1000, 4'b1000, 4'b0001};
      sen[3] = 1'b1;
      wait_ack(3);
      sen[0] = 1'b1;
      wait_rx(3);
      checks++;
      if (rx_q.size() != 3) begin
         errors++;
         $display("FAIL abandon_count got %0d want 3", rx_q.size());
      end
      for (int k = 0; k < 3 && k < rx_q.size(); k++) begin
         checks++;
         if (rx_q[k] !== exp_q[k] || g_q[k] !== eg_q[k]) begin
            errors++;
            $display("FAIL abandon_byte%0d got %h/%b want %h/%b", k, rx_q[k], g_q[k], exp_q[k], eg_q[k]);
         end
      end
   endtask

   task automatic test_timeout();
      int c;
      clear_sources();
      do_reset();
      tx_en = 1'b0;
      add_byte(0, 8'h99, 1'b1);
      sen[0] = 1'b1;
      c = 0;
      while (!tx_start && c < 50) begin
         @(negedge clk);
         c++;
      end
      c = 0;
      while (!err && c < 60) begin
         @(negedge clk);
         c++;
      end
      checks++;
      if (c != MAXW + 1) begin
         errors++;
         $display("FAIL timeout_latency got %0d want %0d", c, MAXW + 1);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || grant !== 4'b0000) begin
         errors++;
         $display("FAIL timeout_pulse err %b grant %b want 0 0000", err, grant);
      end
      tx_en = 1'b1;
      add_byte(1, 8'h77, 1'b1);
      sen[1] = 1'b1;
      wait_rx(1);
      checks++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h77) begin
         errors++;
         $display("FAIL timeout_recover got size %0d want 1 byte 77", rx_q.size());
      end
   endtask

   task automatic test_random();
      int m [N];
      int ptr;
      int w;
      int total;
      bit l;
      for (int it = 0; it < 4; it++) begin
         clear_sources();
         do_reset();
         for (int i = 0; i < N; i++) begin
            int npk = int'($urandom_range(1, 3));
            for (int p = 0; p < npk; p++) begin
               int len = int'($urandom_range(1, 4));
               for (int b = 0; b < len; b++) add_byte(i, 8'($urandom), b == len - 1);
            end
         end
         // packet-level round robin: whole packet from first pending source at/after ptr
         ptr = 0;
         total = 0;
         for (int i = 0; i < N; i++) begin
            m[i] = 0;
            total += slen[i];
         end
         while (exp_q.size() < total) begin
            w = ptr;
            while (m[w] >= slen[w]) w = (w + 1) % N;
            do begin
               exp_q.push_back(sd[w][m[w]]);
               eg_q.push_back(4'(1 << w));
               l = sl[w][m[w]];
               m[w]++;
            end while (!l);
            ptr = (w + 1) % N;
         end
         for (int i = 0; i < N; i++) sen[i] = 1'b1;
         wait_rx(total);
         checks++;
         if (rx_q.size() != total) begin
            errors++;
            $display("FAIL rand%0d_count got %0d want %0d", it, rx_q.size(), total);
         end
         for (int k = 0; k < total && k < rx_q.size(); k++) begin
            checks++;
            if (rx_q[k] !== exp_q[k] || g_q[k] !== eg_q[k]) begin
               errors++;
               $display("FAIL rand%0d_byte%0d got %h/%b want %h/%b",
                        it, k, rx_q[k], g_q[k], exp_q[k], eg_q[k]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      clear_sources();
      test_reset();
      test_single();
      test_round_robin();
      test_packet_lock();
      test_abandon();
      test_timeout();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
